// File: rtl/gray_pkg.sv
// Shared definitions for the Gray-code step checker: FSM encoding and
// small Gray-code helpers used by the checker and its decoder.
package gray_pkg;

    // Widest Gray word the helper functions accept; narrower words are
    // passed zero-extended, which leaves the decode of the low bits unchanged.
    localparam int GRAY_MAX_W = 32;

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_TRACK = 1'b1
    } gray_state_t;

    // Gray to binary: each binary bit is the XOR of all Gray bits at or above
    // it. Zero upper bits contribute nothing, so this works for any N <= 32.
    function automatic logic [GRAY_MAX_W-1:0] gray_to_bin_f(
        input logic [GRAY_MAX_W-1:0] g
    );
        logic [GRAY_MAX_W-1:0] b;
        b = '0;
        for (int i = 0; i < GRAY_MAX_W; i++) begin
            b[i] = ^(g >> i);
        end
        return b;
    endfunction

    // True when exactly one bit of v is set.
    function automatic logic is_onehot(input logic [GRAY_MAX_W-1:0] v);
        return (v != '0) && ((v & (v - 1'b1)) == '0);
    endfunction

endpackage

// File: rtl/gray_step_checker_gray_to_bin.sv
// Combinational N-bit Gray to binary decoder.
module gray_to_bin #(
    parameter int N = 4
) (
    input  logic [N-1:0] gray,
    output logic [N-1:0] bin
);

    // MSB passes through; every lower bit folds in the decoded bit above it.
    always_comb begin
        bin = '0;
        bin[N-1] = gray[N-1];
        for (int i = N - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
    end

endmodule

// File: rtl/gray_step_checker.sv
// Monitor for an N-bit Gray counter: decodes the sampled Gray value to
// binary with one clock of latency and classifies each transition as a
// legal +1 step, a wrap, or an error, including enable-timing checks.
//
// Timing relation with the counter: the counter advances on the edge where
// clk_en is sampled high, so a step shows up on gray_in one cycle after
// clk_en. The checker therefore compares each new step with en_q, the
// enable registered one cycle earlier.
module gray_step_checker
    import gray_pkg::*;
#(
    parameter int N        = 4,
    parameter int CNT_W    = 8,
    parameter bit CHECK_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clk_en,
    input  logic [N-1:0]     gray_in,
    input  logic             clr_err,
    output logic [N-1:0]     bin_out,
    output logic             bin_valid,
    output logic             step_pulse,
    output logic             wrap_pulse,
    output logic             step_err,
    output logic [CNT_W-1:0] err_count,
    output logic             err_sticky
);

    gray_state_t  state;
    logic [N-1:0] g_q;
    logic [N-1:0] b_q;
    logic         en_q;

    logic [N-1:0] b_new;
    logic [N-1:0] b_inc;
    logic [N-1:0] d;
    logic         ev_step;
    logic         ev_wrap;
    logic         ev_err;

    gray_to_bin #(.N(N)) u_dec (
        .gray (gray_in),
        .bin  (b_new)
    );

    assign b_inc   = b_q + 1'b1;
    assign d       = gray_in ^ g_q;
    assign bin_out = b_q;

    // Classify the transition from the stored baseline to the current sample.
    always_comb begin
        ev_step = 1'b0;
        ev_wrap = 1'b0;
        ev_err  = 1'b0;
        if (state == ST_TRACK) begin
            if (d == '0) begin
                // No change: only an error if a step was expected.
                ev_err = CHECK_EN && en_q;
            end else if (is_onehot(GRAY_MAX_W'(d)) && (b_new == b_inc)) begin
                if (CHECK_EN && !en_q) begin
                    ev_err = 1'b1;
                end else begin
                    ev_step = 1'b1;
                    ev_wrap = (b_q == {N{1'b1}});
                end
            end else begin
                ev_err = 1'b1;
            end
        end
    end

    // Sample pipeline, FSM, registered pulses and error accounting.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= ST_INIT;
            g_q        <= '0;
            b_q        <= '0;
            en_q       <= 1'b0;
            bin_valid  <= 1'b0;
            step_pulse <= 1'b0;
            wrap_pulse <= 1'b0;
            step_err   <= 1'b0;
            err_count  <= '0;
            err_sticky <= 1'b0;
        end else begin
            // The baseline always advances, even after an error.
            g_q  <= gray_in;
            b_q  <= b_new;
            en_q <= clk_en;

            step_pulse <= ev_step;
            wrap_pulse <= ev_wrap;
            step_err   <= ev_err;

            case (state)
                ST_INIT: begin
                    state     <= ST_TRACK;
                    bin_valid <= 1'b1;
                end
                ST_TRACK: begin
                    state <= ST_TRACK;
                end
                default: begin
                    state <= ST_INIT;
                end
            endcase

            // A clear in the same cycle as a new error keeps that error.
            if (clr_err) begin
                err_count  <= ev_err ? CNT_W'(1) : '0;
                err_sticky <= ev_err;
            end else if (ev_err) begin
                err_sticky <= 1'b1;
                if (err_count != {CNT_W{1'b1}}) begin
                    err_count <= err_count + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_gray_step_checker.sv
// Directed bench for gray_step_checker (N=4, CNT_W=8, CHECK_EN=1) with a
// transition-level reference model compared on every cycle.
module tb_gray_step_checker;

    logic       clk;
    logic       rst;
    logic       clk_en;
    logic [3:0] gray_in;
    logic       clr_err;
    logic [3:0] bin_out;
    logic       bin_valid;
    logic       step_pulse;
    logic       wrap_pulse;
    logic       step_err;
    logic [7:0] err_count;
    logic       err_sticky;

    int total = 0;
    int bad   = 0;

    gray_step_checker #(.N(4), .CNT_W(8), .CHECK_EN(1'b1)) dut (
        .clk        (clk),
        .rst        (rst),
        .clk_en     (clk_en),
        .gray_in    (gray_in),
        .clr_err    (clr_err),
        .bin_out    (bin_out),
        .bin_valid  (bin_valid),
        .step_pulse (step_pulse),
        .wrap_pulse (wrap_pulse),
        .step_err   (step_err),
        .err_count  (err_count),
        .err_sticky (err_sticky)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference decode by search: the binary k whose Gray code is g.
    function automatic int g2b(input logic [3:0] g);
        for (int k = 0; k < 16; k++) begin
            if (4'(k ^ (k >> 1)) == g) return k;
        end
        return -1;
    endfunction

    // Model state, expressed as counter values rather than register bits.
    int m_bin = 0, m_valid = 0, m_step = 0, m_wrap = 0, m_err = 0;
    int m_cnt = 0, m_sticky = 0, m_tracking = 0, m_prev_val = 0, m_prev_en = 0;

    // Model update on each edge, then compare every DUT output 1 time unit later.
    initial begin
        forever begin
            @(posedge clk);
            if (!rst) begin
                m_bin = 0; m_valid = 0; m_step = 0; m_wrap = 0; m_err = 0;
                m_cnt = 0; m_sticky = 0; m_tracking = 0; m_prev_val = 0; m_prev_en = 0;
            end else begin
                int nv;
                nv = g2b(gray_in);
                m_step = 0; m_wrap = 0; m_err = 0;
                if (m_tracking != 0) begin
                    if (nv == m_prev_val) m_err = m_prev_en;
                    else if (nv == (m_prev_val + 1) % 16) begin
                        if (m_prev_en == 0) m_err = 1;
                        else begin
                            m_step = 1;
                            m_wrap = (m_prev_val == 15) ? 1 : 0;
                        end
                    end else m_err = 1;
                end
                m_tracking = 1;
                m_valid = 1;
                if (clr_err) begin
                    m_cnt = m_err;
                    m_sticky = m_err;
                end else if (m_err != 0) begin
                    m_sticky = 1;
                    m_cnt = (m_cnt + 1 > 255) ? 255 : m_cnt + 1;
                end
                m_bin = nv;
                m_prev_val = nv;
                m_prev_en = clk_en;
            end
            #1;
            check("bin_out", bin_out, m_bin);
            check("bin_valid", bin_valid, m_valid);
            check("step_pulse", step_pulse, m_step);
            check("wrap_pulse", wrap_pulse, m_wrap);
            check("step_err", step_err, m_err);
            check("err_count", err_count, m_cnt);
            check("err_sticky", err_sticky, m_sticky);
        end
    end

    // Driver: apply inputs at the falling edge, return just after the next rising edge.
    task automatic cyc(input logic [3:0] g, input logic en, input logic c);
        @(negedge clk);
        gray_in = g;
        clk_en  = en;
        clr_err = c;
        @(posedge clk);
        #2;
    endtask

    logic [3:0] seq [4] = '{4'b0001, 4'b0011, 4'b0010, 4'b0110};
    logic [3:0] prev_g;

    initial begin
        rst = 1'b0; clk_en = 1'b0; gray_in = 4'b0110; clr_err = 1'b0;

        // 1: reset held, then first sample is the baseline
        repeat (3) cyc(4'b0110, 1'b0, 1'b0);
        check("rst_bin", bin_out, 0);
        check("rst_valid", bin_valid, 0);
        check("rst_cnt", err_count, 0);
        rst = 1'b1;
        cyc(4'b0110, 1'b0, 1'b0);
        check("init_bin", bin_out, 4);
        check("init_valid", bin_valid, 1);
        check("init_pulse", step_pulse | wrap_pulse | step_err, 0);

        // 2: enabled steps 0 -> 4
        rst = 1'b0; cyc(4'b0000, 1'b0, 1'b0);
        rst = 1'b1; cyc(4'b0000, 1'b0, 1'b0);
        prev_g = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            cyc(prev_g, 1'b1, 1'b0);
            cyc(seq[i], 1'b0, 1'b0);
            check("step_bin", bin_out, i + 1);
            check("step_p", step_pulse, 1);
            prev_g = seq[i];
        end
        check("step_noerr", err_count, 0);

        // 3: wrap 15 -> 0
        rst = 1'b0; cyc(4'b1000, 1'b0, 1'b0);
        rst = 1'b1; cyc(4'b1000, 1'b0, 1'b0);
        check("wrap_base", bin_out, 15);
        cyc(4'b1000, 1'b1, 1'b0);
        cyc(4'b0000, 1'b0, 1'b0);
        check("wrap_step", step_pulse, 1);
        check("wrap_p", wrap_pulse, 1);
        check("wrap_bin", bin_out, 0);

        // 4: multi-bit jump, then missed step
        cyc(4'b0000, 1'b1, 1'b0);
        cyc(4'b0011, 1'b1, 1'b0);
        check("jump_err", step_err, 1);
        check("jump_cnt", err_count, 1);
        check("jump_sticky", err_sticky, 1);
        cyc(4'b0011, 1'b1, 1'b0);
        check("miss_err", step_err, 1);
        check("miss_cnt", err_count, 2);

        // 5: backward 2 -> 1, unexpected step 1 -> 2, backward again
        cyc(4'b0001, 1'b0, 1'b0);
        check("back_err", step_err, 1);
        cyc(4'b0011, 1'b0, 1'b0);
        check("unexp_err", step_err, 1);
        check("unexp_step", step_pulse, 0);
        cyc(4'b0001, 1'b0, 1'b0);
        check("back2_err", step_err, 1);
        check("back2_cnt", err_count, 5);

        // 6: saturate, clear with error, clear alone
        for (int i = 0; i < 260; i++) begin
            cyc((i % 2 == 0) ? 4'b0011 : 4'b0000, 1'b0, 1'b0);
        end
        check("sat_cnt", err_count, 255);
        cyc(4'b0011, 1'b0, 1'b1);
        check("clr_err_cnt", err_count, 1);
        check("clr_err_sticky", err_sticky, 1);
        cyc(4'b0011, 1'b0, 1'b1);
        check("clr_cnt", err_count, 0);
        check("clr_sticky", err_sticky, 0);

        // reset mid-operation: first sample after reset is not checked
        cyc(4'b0000, 1'b1, 1'b0);
        rst = 1'b0; cyc(4'b0101, 1'b1, 1'b0);
        check("mid_rst_cnt", err_count, 0);
        rst = 1'b1; cyc(4'b0101, 1'b1, 1'b0);
        check("mid_init_err", step_err, 0);
        check("mid_init_bin", bin_out, 6);
        cyc(4'b0101, 1'b0, 1'b0);
        check("mid_miss_err", step_err, 1);
        cyc(4'b0101, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
